// File: rtl/serial_alu_core_if.sv
// Instruction handshake bundle between a requester (master) and serial_alu_core (slave).
// Carries the instruction word, its valid/ready pair and the completion/abort pulses.
interface serial_alu_core_if #(
  parameter int unsigned OP_WIDTH = 2,
  parameter int unsigned AW       = 2
);
  logic [OP_WIDTH+3*AW-1:0] i_instr;
  logic                     i_instr_valid;
  logic                     o_instr_ready;
  logic                     o_done;
  logic                     o_timeout;

  modport master (
    output i_instr, i_instr_valid,
    input  o_instr_ready, o_done, o_timeout
  );

  modport slave (
    input  i_instr, i_instr_valid,
    output o_instr_ready, o_done, o_timeout
  );
endinterface

// File: rtl/serial_alu_core.sv
// Serial core: register bank plus an SPI-style offload link to an external ALU.
// Define SERIAL_ALU_CORE_TIMEOUT_EN to compile in the ALU response watchdog.
module serial_alu_core #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned REG_COUNT      = 4,
  parameter int unsigned OP_WIDTH       = 2,
  parameter int unsigned TIMEOUT_CYCLES = 16,
  localparam int unsigned AW            = $clog2(REG_COUNT)
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  serial_alu_core_if.slave      instr_if,
  input  logic                  i_dbg_we,
  input  logic [AW-1:0]         i_dbg_addr,
  input  logic [DATA_WIDTH-1:0] i_dbg_wdata,
  output logic [DATA_WIDTH-1:0] o_dbg_rdata,
  output logic                  o_spi_sclk,
  output logic                  o_spi_nss,
  output logic                  o_spi_mosi,
  input  logic                  i_spi_miso
);
  localparam int unsigned IW = OP_WIDTH + 3 * AW;
  localparam int unsigned P  = OP_WIDTH + 2 * DATA_WIDTH;
  localparam int unsigned CW = $clog2(P);

  typedef enum logic [2:0] {
    StIdle, StLoad, StStart, StSend, StWait, StRecv, StWb, StAbort
  } state_e;

  state_e                state_q, state_d;
  logic [IW-1:0]         instr_q, instr_d;
  logic [P-1:0]          pkt_q, pkt_d;
  logic [DATA_WIDTH-1:0] res_q, res_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] regs_q [REG_COUNT];
  logic [DATA_WIDTH-1:0] regs_d [REG_COUNT];
  logic                  ready, done, nss, mosi;
  logic [OP_WIDTH-1:0]   op;
  logic [AW-1:0]         rs1, rs2, rd;

`ifdef SERIAL_ALU_CORE_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wdog_q, wdog_d;
  logic          timeout;
`endif

  assign op  = instr_q[IW-1:3*AW];
  assign rs1 = instr_q[3*AW-1:2*AW];
  assign rs2 = instr_q[2*AW-1:AW];
  assign rd  = instr_q[AW-1:0];

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    pkt_d   = pkt_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    regs_d  = regs_q;
    ready   = 1'b0;
    done    = 1'b0;
    nss     = 1'b1;
    mosi    = 1'b0;
`ifdef SERIAL_ALU_CORE_TIMEOUT_EN
    wdog_d  = wdog_q;
    timeout = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        ready = 1'b1;
        // r0 is never written, so it keeps reading as zero
        if (i_dbg_we && (i_dbg_addr != '0)) regs_d[i_dbg_addr] = i_dbg_wdata;
        if (instr_if.i_instr_valid) begin
          instr_d = instr_if.i_instr;
          state_d = StLoad;
        end
      end
      StLoad: begin
        pkt_d   = {regs_q[rs2], regs_q[rs1], op};
        state_d = StStart;
      end
      StStart: begin
        nss     = 1'b0;
        mosi    = 1'b1;
        state_d = StSend;
      end
      StSend: begin
        nss   = 1'b0;
        mosi  = pkt_q[0];
        pkt_d = pkt_q >> 1;
        if (cnt_q == CW'(P - 1)) begin
          cnt_d   = '0;
          state_d = StWait;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      StWait: begin
        nss = 1'b0;
        if (i_spi_miso) begin
          state_d = StRecv;
`ifdef SERIAL_ALU_CORE_TIMEOUT_EN
          wdog_d  = '0;
        end else if (wdog_q == TW'(TIMEOUT_CYCLES - 1)) begin
          state_d = StAbort;
          wdog_d  = '0;
        end else begin
          wdog_d = wdog_q + TW'(1);
`endif
        end
      end
      StRecv: begin
        nss   = 1'b0;
        res_d = {i_spi_miso, res_q[DATA_WIDTH-1:1]};
        if (cnt_q == CW'(DATA_WIDTH - 1)) begin
          cnt_d   = '0;
          state_d = StWb;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      StWb: begin
        done = 1'b1;
        if (rd != '0) regs_d[rd] = res_q;
        state_d = StIdle;
      end
`ifdef SERIAL_ALU_CORE_TIMEOUT_EN
      StAbort: begin
        timeout = 1'b1;
        state_d = StIdle;
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= StIdle;
      instr_q <= '0;
      pkt_q   <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      regs_q  <= '{default: '0};
`ifdef SERIAL_ALU_CORE_TIMEOUT_EN
      wdog_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      pkt_q   <= pkt_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      regs_q  <= regs_d;
`ifdef SERIAL_ALU_CORE_TIMEOUT_EN
      wdog_q  <= wdog_d;
`endif
    end
  end

  assign instr_if.o_instr_ready = ready;
  assign instr_if.o_done        = done;
`ifdef SERIAL_ALU_CORE_TIMEOUT_EN
  assign instr_if.o_timeout     = timeout;
`else
  assign instr_if.o_timeout     = 1'b0;
`endif
  assign o_dbg_rdata = regs_q[i_dbg_addr];
  assign o_spi_sclk  = i_clock;
  assign o_spi_nss   = nss;
  assign o_spi_mosi  = mosi;
endmodule

// File: tb/tb_serial_alu_core.sv
// Bench for serial_alu_core: vector table plus hand sequences, with an SPI ALU model and a
// scoreboard of expected packets/results.
module tb_serial_alu_core;
  localparam int unsigned DW  = 8;
  localparam int unsigned RC  = 4;
  localparam int unsigned OPW = 2;
  localparam int unsigned AW  = 2;
  localparam int unsigned P   = OPW + 2 * DW;

  typedef struct {
    logic [P-1:0]  pkt;
    logic [DW-1:0] res;
    logic [AW-1:0] rd;
  } txn_t;

  typedef struct {
    logic [OPW-1:0] op;
    logic [AW-1:0]  rs1;
    logic [AW-1:0]  rs2;
    logic [AW-1:0]  rd;
    logic [DW-1:0]  v1;
    logic [DW-1:0]  v2;
    logic [DW-1:0]  exp_rd;
    int             delay;
    int             exp_lat;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          dbg_we;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata, dbg_rdata;
  logic          sclk, nss, mosi;
  logic          miso;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int hs_cnt = 0;
  int done_cnt = 0;
  int alu_delay = 0;
  bit alu_mute = 1'b0;

  txn_t         exp_q[$];
  logic [P-1:0] got_q[$];
  vec_t         vecs[7];

  serial_alu_core_if #(.OP_WIDTH(OPW), .AW(AW)) instr_if ();

  serial_alu_core #(
    .DATA_WIDTH(DW), .REG_COUNT(RC), .OP_WIDTH(OPW), .TIMEOUT_CYCLES(16)
  ) dut (
    .i_clock    (clk),
    .i_reset    (rst_n),
    .instr_if   (instr_if),
    .i_dbg_we   (dbg_we),
    .i_dbg_addr (dbg_addr),
    .i_dbg_wdata(dbg_wdata),
    .o_dbg_rdata(dbg_rdata),
    .o_spi_sclk (sclk),
    .o_spi_nss  (nss),
    .o_spi_mosi (mosi),
    .i_spi_miso (miso)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (instr_if.i_instr_valid && instr_if.o_instr_ready) hs_cnt <= hs_cnt + 1;
    if (instr_if.o_done) done_cnt <= done_cnt + 1;
  end

  // ALU ops: 0 and, 1 sub, 2 add, 3 xor
  function automatic logic [DW-1:0] alu_fn(input logic [P-1:0] p);
    logic [OPW-1:0] op = p[OPW-1:0];
    logic [DW-1:0]  a  = p[OPW+DW-1:OPW];
    logic [DW-1:0]  b  = p[P-1:OPW+DW];
    case (op)
      2'd0:    return a & b;
      2'd1:    return a - b;
      2'd2:    return a + b;
      default: return a ^ b;
    endcase
  endfunction

  // ALU model: start bit, P bits LSB first, optional delay, then start bit + result
  int           astate, acnt;
  logic [P-1:0] apkt;
  logic [DW-1:0] ares;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      astate <= 0;
      acnt   <= 0;
      apkt   <= '0;
      ares   <= '0;
      miso   <= 1'b0;
    end else begin
      case (astate)
        0: if (!nss && mosi) begin
          acnt   <= 0;
          astate <= 1;
        end
        1: begin
          apkt <= {mosi, apkt[P-1:1]};
          if (acnt == P - 1) begin
            got_q.push_back({mosi, apkt[P-1:1]});
            acnt   <= 0;
            astate <= 2;
          end else acnt <= acnt + 1;
        end
        2: if (nss) astate <= 0;
           else if (!alu_mute) begin
             if (acnt == alu_delay) begin
               miso   <= 1'b1;
               ares   <= alu_fn(apkt);
               acnt   <= 0;
               astate <= 3;
             end else acnt <= acnt + 1;
           end
        3: begin
          miso <= ares[0];
          ares <= ares >> 1;
          if (acnt == DW - 1) astate <= 4;
          else acnt <= acnt + 1;
        end
        default: begin
          miso   <= 1'b0;
          astate <= 0;
        end
      endcase
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic dbg_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    dbg_we = 1'b1; dbg_addr = a; dbg_wdata = d;
    @(negedge clk);
    dbg_we = 1'b0;
  endtask

  task automatic issue(input logic [OPW-1:0] op, input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                       input logic [AW-1:0] rd, input bit hold, output int hs);
    @(negedge clk);
    instr_if.i_instr = {op, rs1, rs2, rd};
    instr_if.i_instr_valid = 1'b1;
    @(negedge clk);
    hs = cyc;
    if (!hold) instr_if.i_instr_valid = 1'b0;
  endtask

  task automatic wait_event(input bit want_to, input int budget, output int at, output bit seen);
    seen = 1'b0;
    at = 0;
    for (int i = 0; i < budget; i++) begin
      if (want_to ? instr_if.o_timeout : instr_if.o_done) begin
        seen = 1'b1;
        at = cyc + 1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic finish_txn(input string name, input int hs, input int lat);
    int at;
    bit seen;
    txn_t e;
    logic [P-1:0] g;
    wait_event(1'b0, 200, at, seen);
    instr_if.i_instr_valid = 1'b0;
    check({name, " done seen"}, 32'(seen), 32'd1);
    if (seen) check({name, " latency"}, 32'(at - hs), 32'(lat));
    e = exp_q.pop_front();
    g = (got_q.size() != 0) ? got_q.pop_front() : 'x;
    check({name, " packet"}, 32'(g), 32'(e.pkt));
    @(negedge clk);
    dbg_addr = e.rd;
    #1;
    check({name, " writeback"}, 32'(dbg_rdata), 32'(e.res));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global time limit reached");
    $fatal(1, "simulation stuck");
  end

  initial begin
    int hs, at, hs0, d0;
    bit seen;
    instr_if.i_instr = '0;
    instr_if.i_instr_valid = 1'b0;
    dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;

    vecs[0] = '{2'd2, 2'd1, 2'd2, 2'd3, 8'h35, 8'hA4, 8'hD9, 0, 31};
    vecs[1] = '{2'd0, 2'd2, 2'd1, 2'd1, 8'hF0, 8'h3C, 8'h30, 0, 31};
    vecs[2] = '{2'd3, 2'd1, 2'd2, 2'd2, 8'hAA, 8'h55, 8'hFF, 0, 31};
    vecs[3] = '{2'd1, 2'd3, 2'd1, 2'd3, 8'h05, 8'h07, 8'hFE, 0, 31};
    vecs[4] = '{2'd1, 2'd3, 2'd3, 2'd3, 8'h10, 8'h10, 8'h00, 0, 31};
    vecs[5] = '{2'd2, 2'd1, 2'd2, 2'd0, 8'h01, 8'h02, 8'h00, 0, 31};
    vecs[6] = '{2'd2, 2'd2, 2'd1, 2'd3, 8'h80, 8'h7F, 8'hFF, 7, 38};

    repeat (2) @(negedge clk);
    check("reset ready", 32'(instr_if.o_instr_ready), 32'd1);
    check("reset done", 32'(instr_if.o_done), 32'd0);
    check("reset timeout", 32'(instr_if.o_timeout), 32'd0);
    check("reset nss", 32'(nss), 32'd1);
    check("reset mosi", 32'(mosi), 32'd0);
    check("sclk follows clock", 32'(sclk), 32'(clk));
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      dbg_write(vecs[i].rs1, vecs[i].v1);
      dbg_write(vecs[i].rs2, vecs[i].v2);
      alu_delay = vecs[i].delay;
      exp_q.push_back('{{vecs[i].v2, vecs[i].v1, vecs[i].op}, vecs[i].exp_rd, vecs[i].rd});
      issue(vecs[i].op, vecs[i].rs1, vecs[i].rs2, vecs[i].rd, 1'b0, hs);
      finish_txn($sformatf("vec%0d", i), hs, vecs[i].exp_lat);
    end
    alu_delay = 0;
    check("done pulse count", 32'(done_cnt), 32'd7);

    // Debug write coinciding with the handshake must be seen by LOAD
    dbg_write(2'd1, 8'h20);
    dbg_write(2'd2, 8'h01);
    @(negedge clk);
    dbg_we = 1'b1; dbg_addr = 2'd2; dbg_wdata = 8'h40;
    instr_if.i_instr = {2'd2, 2'd1, 2'd2, 2'd3};
    instr_if.i_instr_valid = 1'b1;
    exp_q.push_back('{{8'h40, 8'h20, 2'd2}, 8'h60, 2'd3});
    @(negedge clk);
    hs = cyc;
    dbg_we = 1'b0;
    instr_if.i_instr_valid = 1'b0;
    finish_txn("same-cycle dbg", hs, 31);

    // Valid held through a transaction, debug write attempted during SEND
    dbg_write(2'd1, 8'h35);
    dbg_write(2'd2, 8'h0B);
    hs0 = hs_cnt;
    exp_q.push_back('{{8'h0B, 8'h35, 2'd2}, 8'h40, 2'd3});
    issue(2'd2, 2'd1, 2'd2, 2'd3, 1'b1, hs);
    repeat (2) @(negedge clk);
    dbg_write(2'd1, 8'hFF);
    finish_txn("backpressure", hs, 31);
    check("one handshake", 32'(hs_cnt - hs0), 32'd1);
    dbg_addr = 2'd1;
    #1;
    check("dbg lockout r1", 32'(dbg_rdata), 32'h35);

`ifdef SERIAL_ALU_CORE_TIMEOUT_EN
    dbg_write(2'd3, 8'h5A);
    alu_mute = 1'b1;
    d0 = done_cnt;
    issue(2'd2, 2'd1, 2'd2, 2'd3, 1'b0, hs);
    wait_event(1'b1, 100, at, seen);
    check("timeout seen", 32'(seen), 32'd1);
    check("timeout latency", 32'(at - hs), 32'd37);
    check("timeout nss", 32'(nss), 32'd1);
    @(negedge clk);
    check("timeout one cycle", 32'(instr_if.o_timeout), 32'd0);
    check("ready after timeout", 32'(instr_if.o_instr_ready), 32'd1);
    check("no done on timeout", 32'(done_cnt - d0), 32'd0);
    dbg_addr = 2'd3;
    #1;
    check("rd kept on timeout", 32'(dbg_rdata), 32'h5A);
    alu_mute = 1'b0;
    void'(got_q.pop_front());
`endif

    // Reset in the middle of SEND
    dbg_write(2'd1, 8'h77);
    issue(2'd2, 2'd1, 2'd2, 2'd3, 1'b0, hs);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid reset nss", 32'(nss), 32'd1);
    check("mid reset ready", 32'(instr_if.o_instr_ready), 32'd1);
    for (int a = 0; a < RC; a++) begin
      dbg_addr = AW'(a);
      #1;
      check($sformatf("mid reset r%0d", a), 32'(dbg_rdata), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    got_q.delete();
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/serial_alu_core.md
# serial_alu_core

Parametrised serial processor core that owns a register bank and offloads every arithmetic operation to an external ALU over a 4-wire SPI-style link. It accepts one instruction at a time through a valid/ready handshake and serialises the opcode and both operands to the ALU. It then waits for the ALU's start bit, deserialises the result and writes it back to the destination register. A debug port reads and writes the register bank directly, and an optional watchdog aborts transactions the ALU never answers.

## Interface
- DATA_WIDTH, 8: register and ALU result width, ≥2.
- REG_COUNT, 4: number of registers, power of two ≥2; AW = $clog2(REG_COUNT).
- OP_WIDTH, 2: ALU opcode width, ≥1.
- TIMEOUT_CYCLES, 16: response watchdog limit, ≥1; used only with the watchdog compiled in.
- i_clock  in  1  system clock.
- i_reset  in  1  asynchronous, active-low reset.
- i_instr  in  OP_WIDTH+3·AW  instruction {op, rs1, rs2, rd}, op in the MSBs.
- i_instr_valid  in  1  instruction offered.
- o_instr_ready  out  1  core can accept an instruction.
- o_done  out  1  one-cycle pulse at writeback.
- o_timeout  out  1  one-cycle pulse on a watchdog abort.
- i_dbg_we  in  1  debug write enable.
- i_dbg_addr  in  AW  debug register address.
- i_dbg_wdata  in  DATA_WIDTH  debug write data.
- o_dbg_rdata  out  DATA_WIDTH  combinational read of registers[i_dbg_addr].
- o_spi_sclk  out  1  equals i_clock.
- o_spi_nss  out  1  active-low select.
- o_spi_mosi  out  1  master data out.
- i_spi_miso  in  1  ALU data in.

## Operation
- Register 0 reads as zero. Writes to r0 from writeback or from the debug port are discarded.
- States and transitions:
  - IDLE: o_instr_ready=1. A handshake (valid & ready) latches i_instr and moves to LOAD.
  - LOAD: latch the shift packet {registers[rs2], registers[rs1], op}. Move to START.
  - START: nss=0, mosi=1. Move to SEND.
  - SEND: mosi = packet bit k, LSB first (op LSB first), for P = OP_WIDTH+2·DATA_WIDTH cycles. After the last bit, move to WAIT.
  - WAIT: nss=0, mosi=0. When i_spi_miso is sampled 1, move to RECV.
  - RECV: shift DATA_WIDTH bits from miso, LSB first. Move to WB.
  - WB: registers[rd] <= result; o_done=1. Move to IDLE.
- Operands are captured in LOAD, so rd equal to rs1 or rs2 is safe.
- In IDLE: nss=1, mosi=0.
- Debug writes are honoured only in IDLE and ignored in every other state.
  - A debug write in the same cycle as an instruction handshake lands before LOAD, so the new value is used.
- i_instr_valid while not ready is ignored; the core holds no queue.
- Bit counters wrap to 0 on every state exit.
- Reset mid-transaction: immediate return to IDLE with nss=1. Registers are cleared and no writeback occurs.

## Timing
- Reset values:
  - o_instr_ready=1, o_done=0, o_timeout=0, o_spi_nss=1, o_spi_mosi=0.
  - All registers, counters and shift registers = 0; state = IDLE.
- mosi and nss change only after a rising clock edge. The ALU samples them on the next rising edge.
- Handshake at edge 0 gives:
  - LOAD in cycle 1;
  - START in cycle 2;
  - SEND in cycles 3..P+2;
  - WAIT from cycle P+3.
- A miso start bit sampled at edge n puts the first result bit at edge n+1 and the last at edge n+DATA_WIDTH. WB follows.
- Minimum instruction latency, handshake to o_done, with a zero-wait ALU: P+DATA_WIDTH+5 cycles. With defaults this is 31 cycles.
- o_instr_ready rises on the cycle after WB.

## Configuration
- SERIAL_ALU_CORE_TIMEOUT_EN defined:
  - A counter runs in WAIT.
  - If no start bit has arrived after TIMEOUT_CYCLES cycles in WAIT, the core pulses o_timeout for one cycle, drives nss=1 and returns to IDLE.
  - rd is unchanged and o_done stays 0.
  - A start bit in the final counted cycle wins over the timeout.
- Not defined: WAIT blocks indefinitely and o_timeout is tied 0.

## Test plan
- Reset: assert i_reset=0 mid-SEND → nss=1, ready=1, o_dbg_rdata=0 for every address.
- Basic op: debug-write r1=0x35 and r2=0xA4; issue {op=2, rs1=1, rs2=2, rd=3}. Required response:
  - mosi shows 1, then 18 bits LSB-first encoding op=2, 0x35, 0xA4;
  - the ALU model replies start bit then 0xD9;
  - o_done occurs 31 cycles after the handshake with a zero-wait model, and r3=0xD9.
- Aliasing and r0: {op=1, rs1=3, rs2=3, rd=3} with r3=0x10 → operands 0x10 and 0x10 sent and r3 gets the result. Then rd=0 → r0 still reads 0.
- Backpressure and debug lockout: hold valid high through a transaction and debug-write r1=0xFF during SEND → only one handshake per transaction and r1 unchanged.
- ALU delay: the model waits 7 cycles before the start bit → o_done exactly 7 cycles later than the zero-wait case.
- Watchdog (macro defined): the ALU never replies → o_timeout pulses after 16 WAIT cycles, nss=1, rd unchanged, ready=1 the next cycle.
